// File: rtl/sram_bank_arbiter.sv
// Two-client arbiter for the dual-word-line SRAM bank; decodes row addresses to one-hot word lines.
// Latency: array command registered one cycle after accept, read return visible two cycles after accept.
// Backpressure: a client is held off by deasserting its gnt; nothing is queued, the client keeps its request.
module sram_bank_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter bit DUAL_READ = 1'b1
) (
  input  logic                   srclkpos,
  input  logic                   reset,
  input  logic                   r0_req,
  input  logic                   r0_we,
  input  logic [ADDR_W-1:0]      r0_addr,
  input  logic [DATA_W-1:0]      r0_wdata,
  output logic                   r0_gnt,
  output logic                   r0_rvalid,
  output logic [DATA_W-1:0]      r0_rdata,
  input  logic                   r1_req,
  input  logic                   r1_we,
  input  logic [ADDR_W-1:0]      r1_addr,
  input  logic [DATA_W-1:0]      r1_wdata,
  output logic                   r1_gnt,
  output logic                   r1_rvalid,
  output logic [DATA_W-1:0]      r1_rdata,
  output logic [2**ADDR_W-1:0]   wordA,
  output logic [2**ADDR_W-1:0]   wordB,
  output logic                   ReadEn,
  output logic                   WriteEn,
  output logic [DATA_W-1:0]      din,
  input  logic [DATA_W-1:0]      outA,
  input  logic [DATA_W-1:0]      outB
);

  localparam int DEPTH = 2**ADDR_W;

  // Which requester wins the next contended cycle.
  typedef enum logic {
    PRI_R0 = 1'b0,
    PRI_R1 = 1'b1
  } rrPtr_t;

  // Bookkeeping that travels with an issued command so the return lands at the right client.
  typedef struct packed {
    logic aRead;   // port A carries a read this cycle
    logic aOwner;  // 0 = requester 0 owns port A, 1 = requester 1
    logic bRead;   // port B carries requester 1's half of a dual read
  } issueTag_t;

  rrPtr_t            rrPtr;
  rrPtr_t            rrNext;
  issueTag_t         issueTag;
  logic              gnt0;
  logic              gnt1;
  logic              bothReq;
  logic              dualRead;
  logic              anyGnt;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  function automatic logic [DEPTH-1:0] oneHot(input logic [ADDR_W-1:0] a);
    logic [DEPTH-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Grant decision and round-robin update; grants are held off while reset is asserted.
  always_comb begin
    bothReq  = r0_req && r1_req;
    dualRead = bothReq && !r0_we && !r1_we && DUAL_READ;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rrNext   = rrPtr;
    if (!reset) begin
      if (dualRead) begin
        gnt0 = 1'b1;
        gnt1 = 1'b1;
      end else if (bothReq) begin
        if (rrPtr == PRI_R0) begin
          gnt0   = 1'b1;
          rrNext = PRI_R1;
        end else begin
          gnt1   = 1'b1;
          rrNext = PRI_R0;
        end
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  // Port A always carries the single op; in a dual read requester 0 takes A and requester 1 takes B.
  always_comb begin
    anyGnt   = gnt0 || gnt1;
    selWe    = gnt0 ? r0_we    : r1_we;
    selAddr  = gnt0 ? r0_addr  : r1_addr;
    selWdata = gnt0 ? r0_wdata : r1_wdata;
  end

  // Round-robin pointer register.
  always_ff @(posedge srclkpos or posedge reset) begin
    if (reset) begin
      rrPtr <= PRI_R0;
    end else begin
      rrPtr <= rrNext;
    end
  end

  // Issue stage: drive the array command and remember who owns each port.
  always_ff @(posedge srclkpos or posedge reset) begin
    if (reset) begin
      wordA    <= '0;
      wordB    <= '0;
      ReadEn   <= 1'b0;
      WriteEn  <= 1'b0;
      din      <= '0;
      issueTag <= '0;
    end else begin
      wordA          <= anyGnt ? oneHot(selAddr) : '0;
      wordB          <= (gnt0 && gnt1) ? oneHot(r1_addr) : '0;
      ReadEn         <= anyGnt && !selWe;
      WriteEn        <= anyGnt && selWe;
      din            <= (anyGnt && selWe) ? selWdata : '0;
      issueTag.aRead  <= anyGnt && !selWe;
      issueTag.aOwner <= !gnt0;
      issueTag.bRead  <= gnt0 && gnt1;
    end
  end

  // Return stage: capture array outputs for the tagged owners; rdata holds between returns.
  always_ff @(posedge srclkpos or posedge reset) begin
    if (reset) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= issueTag.aRead && !issueTag.aOwner;
      r1_rvalid <= (issueTag.aRead && issueTag.aOwner) || issueTag.bRead;
      if (issueTag.aRead && !issueTag.aOwner) begin
        r0_rdata <= outA;
      end
      if (issueTag.bRead) begin
        r1_rdata <= outB;
      end else if (issueTag.aRead && issueTag.aOwner) begin
        r1_rdata <= outA;
      end
    end
  end

endmodule
